// File: rtl/usart_pkg.sv
// Shared USART encodings: character size, parity mode, oversampling and the
// receive FSM state type.
package usart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [2:0] CS_5 = 3'd0;
    localparam logic [2:0] CS_6 = 3'd1;
    localparam logic [2:0] CS_7 = 3'd2;
    localparam logic [2:0] CS_8 = 3'd3;
    localparam logic [2:0] CS_9 = 3'd7;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_EVEN = 2'b10;
    localparam logic [1:0] PM_ODD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Encodings 4..6 are reserved and behave as 8-bit characters.
    function automatic logic [3:0] char_bits(input logic [2:0] cs);
        case (cs)
            CS_5:    return 4'd5;
            CS_6:    return 4'd6;
            CS_7:    return 4'd7;
            CS_9:    return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// RXD synchronizer, per-bit sample counter and 3-sample majority vote around
// the bit centre.
module usart_rx_sampler #(
    parameter int OVERSAMPLE = usart_pkg::OVERSAMPLE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    input  logic i_sample_tick,
    input  logic i_hold,
    output logic o_rxd_sync,
    output logic o_bit_value,
    output logic o_bit_strobe,
    output logic o_bit_end
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;
    logic [CW-1:0] w_cnt_next;

    // w_cnt_next is the count this tick represents; hold pins it at 0.
    always_comb begin
        w_cnt_next = '0;
        if (!i_hold && r_cnt != C_LAST)
            w_cnt_next = r_cnt + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            if (i_hold)
                r_cnt <= '0;
            else if (i_sample_tick)
                r_cnt <= w_cnt_next;
            if (i_sample_tick && w_cnt_next == C_S0)
                r_s0 <= r_sync2;
            if (i_sample_tick && w_cnt_next == C_S1)
                r_s1 <= r_sync2;
        end
    end

    assign o_rxd_sync   = r_sync2;
    assign o_bit_value  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign o_bit_strobe = i_sample_tick && !i_hold && (w_cnt_next == C_S2);
    assign o_bit_end    = i_sample_tick && !i_hold && (w_cnt_next == C_LAST);

endmodule

// File: rtl/usart_rx_deserializer.sv
// USART receive front end: frame FSM, data/parity assembly and the
// valid/ack handshake toward the receive FIFO.
module usart_rx_deserializer
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = usart_pkg::OVERSAMPLE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sample_tick,
    input  logic       i_rxd,
    input  logic       i_rx_enable,
    input  logic [2:0] i_char_size,
    input  logic [1:0] i_parity_mode,
    input  logic       i_shift_register_ack,
    output logic [8:0] o_shift_register,
    output logic       o_shift_register_valid,
    output logic       o_frame_error,
    output logic       o_parity_error,
    output logic       o_data_overrun
);

    rx_state_e  r_state;
    rx_state_e  w_state_next;
    logic [8:0] r_data;
    logic [3:0] r_bit_idx;
    logic       r_par_acc;
    logic       r_par_err;

    logic       w_rxd_sync;
    logic       w_bit_value;
    logic       w_bit_strobe;
    logic       w_bit_end;
    logic       w_hold;
    logic       w_complete;
    logic [3:0] w_n;
    logic       w_par_en;
    logic       w_last_bit;

    assign w_n        = char_bits(i_char_size);
    assign w_par_en   = i_parity_mode[1];
    // ">=" so a mid-frame size change can never strand the index past N-1.
    assign w_last_bit = (r_bit_idx >= w_n - 4'd1);
    assign w_hold     = (r_state == IDLE) || !i_rx_enable;

    usart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rxd         (i_rxd),
        .i_sample_tick (i_sample_tick),
        .i_hold        (w_hold),
        .o_rxd_sync    (w_rxd_sync),
        .o_bit_value   (w_bit_value),
        .o_bit_strobe  (w_bit_strobe),
        .o_bit_end     (w_bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        if (!i_rx_enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (i_sample_tick && !w_rxd_sync) w_state_next = START;
                START: begin
                    if (w_bit_strobe && w_bit_value)
                        w_state_next = IDLE;
                    else if (w_bit_end)
                        w_state_next = DATA;
                end
                DATA:   if (w_bit_end && w_last_bit) w_state_next = w_par_en ? PARITY : STOP;
                PARITY: if (w_bit_end) w_state_next = STOP;
                STOP: begin
                    // Leave at mid-stop so the next start edge is caught early.
                    if (w_bit_strobe) begin
                        w_state_next = IDLE;
                        w_complete   = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data                 <= '0;
            r_bit_idx              <= '0;
            r_par_acc              <= 1'b0;
            r_par_err              <= 1'b0;
            o_shift_register       <= '0;
            o_shift_register_valid <= 1'b0;
            o_frame_error          <= 1'b0;
            o_parity_error         <= 1'b0;
            o_data_overrun         <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_data    <= '0;
                r_bit_idx <= '0;
                r_par_acc <= 1'b0;
                r_par_err <= 1'b0;
            end
            if (r_state == DATA && w_bit_strobe) begin
                r_data    <= r_data | (9'(w_bit_value) << r_bit_idx);
                r_par_acc <= r_par_acc ^ w_bit_value;
            end
            if (r_state == DATA && w_bit_end)
                r_bit_idx <= r_bit_idx + 4'd1;
            if (r_state == PARITY && w_bit_strobe)
                r_par_err <= r_par_acc ^ w_bit_value ^ (i_parity_mode == PM_ODD);

            if (w_complete) begin
                o_shift_register       <= r_data;
                o_frame_error          <= ~w_bit_value;
                o_parity_error         <= w_par_en & r_par_err;
                o_data_overrun         <= o_shift_register_valid & ~i_shift_register_ack;
                o_shift_register_valid <= 1'b1;
            end else if (i_shift_register_ack) begin
                o_shift_register_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usart_rx_deserializer.sv
// Directed bench for the USART receive deserializer: framed serial vectors
// with hand-computed words and status flags.
module tb_usart_rx_deserializer;
    import usart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OVERSAMPLE * TICK_DIV;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_sample_tick = 1'b0;
    logic       i_rxd = 1'b1;
    logic       i_rx_enable = 1'b1;
    logic [2:0] i_char_size = CS_8;
    logic [1:0] i_parity_mode = PM_NONE;
    logic       i_shift_register_ack = 1'b0;
    logic [8:0] o_shift_register;
    logic       o_shift_register_valid;
    logic       o_frame_error;
    logic       o_parity_error;
    logic       o_data_overrun;

    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;
    int   lat = 0;
    event ev_start;

    usart_rx_deserializer dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_sample_tick          (i_sample_tick),
        .i_rxd                  (i_rxd),
        .i_rx_enable            (i_rx_enable),
        .i_char_size            (i_char_size),
        .i_parity_mode          (i_parity_mode),
        .i_shift_register_ack   (i_shift_register_ack),
        .o_shift_register       (o_shift_register),
        .o_shift_register_valid (o_shift_register_valid),
        .o_frame_error          (o_frame_error),
        .o_parity_error         (o_parity_error),
        .o_data_overrun         (o_data_overrun)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(negedge i_clk);
        cyc++;
        i_sample_tick = (cyc % TICK_DIV == 0);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Frames start at a fixed tick phase so completion timing repeats exactly.
    task automatic send_frame(input logic [8:0] d, input int n, input bit pen,
                              input bit pbit, input bit stopb);
        do @(posedge i_clk); while (cyc % TICK_DIV != 1);
        @(negedge i_clk);
        i_rxd = 1'b0;
        -> ev_start;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < n; i++) begin
            i_rxd = d[i];
            wait_clks(BIT_CLKS);
        end
        if (pen) begin
            i_rxd = pbit;
            wait_clks(BIT_CLKS);
        end
        i_rxd = stopb;
        wait_clks(BIT_CLKS);
        i_rxd = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic ack_pulse();
        @(negedge i_clk);
        i_shift_register_ack = 1'b1;
        @(negedge i_clk);
        i_shift_register_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  int'(o_shift_register), 0);
        chk({tag, "_valid"}, int'(o_shift_register_valid), 0);
        chk({tag, "_fe"},    int'(o_frame_error), 0);
        chk({tag, "_pe"},    int'(o_parity_error), 0);
        chk({tag, "_ov"},    int'(o_data_overrun), 0);
    endtask

    initial begin
        wait_clks(5);
        chk_all_zero("reset");
        i_rst = 1'b0;
        wait_clks(BIT_CLKS);

        // 8N1 0xA5, measuring stop-bit completion latency.
        fork
            send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
            begin
                @(ev_start);
                lat = 0;
                while (!o_shift_register_valid && lat < 2000) begin
                    @(posedge i_clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("t1_latency_in_window", int'(lat >= 608 && lat <= 626), 1);
        chk("t1_data",  int'(o_shift_register), 'h0A5);
        chk("t1_valid", int'(o_shift_register_valid), 1);
        chk("t1_fe",    int'(o_frame_error), 0);
        chk("t1_pe",    int'(o_parity_error), 0);
        chk("t1_ov",    int'(o_data_overrun), 0);
        ack_pulse();
        chk("t1_valid_after_ack", int'(o_shift_register_valid), 0);

        // 9-bit even parity, 0x1C3 has five ones so the good parity bit is 1.
        i_char_size   = CS_9;
        i_parity_mode = PM_EVEN;
        send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b1);
        chk("t2_data_good", int'(o_shift_register), 'h1C3);
        chk("t2_pe_good",   int'(o_parity_error), 0);
        ack_pulse();
        send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1);
        chk("t2_data_bad", int'(o_shift_register), 'h1C3);
        chk("t2_pe_bad",   int'(o_parity_error), 1);
        ack_pulse();

        // 5N1 with a broken then a good stop bit.
        i_char_size   = CS_5;
        i_parity_mode = PM_NONE;
        send_frame(9'h015, 5, 1'b0, 1'b0, 1'b0);
        chk("t3_data_fe", int'(o_shift_register), 'h015);
        chk("t3_fe_set",  int'(o_frame_error), 1);
        ack_pulse();
        send_frame(9'h00A, 5, 1'b0, 1'b0, 1'b1);
        chk("t3_data_ok", int'(o_shift_register), 'h00A);
        chk("t3_fe_clr",  int'(o_frame_error), 0);
        ack_pulse();

        // Glitch of 4 ticks, then a real 8N1 frame.
        i_char_size = CS_8;
        @(negedge i_clk);
        i_rxd = 1'b0;
        wait_clks(4 * TICK_DIV);
        i_rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("t4_no_valid", int'(o_shift_register_valid), 0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1);
        chk("t4_data",  int'(o_shift_register), 'h03C);
        chk("t4_valid", int'(o_shift_register_valid), 1);
        ack_pulse();

        // Overrun, then ack landing on the completion cycle.
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1);
        chk("t5_data_ov",  int'(o_shift_register), 'h022);
        chk("t5_ov_set",   int'(o_data_overrun), 1);
        chk("t5_valid_ov", int'(o_shift_register_valid), 1);
        fork
            send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1);
            begin
                @(ev_start);
                repeat (lat - 1) @(negedge i_clk);
                i_shift_register_ack = 1'b1;
                @(negedge i_clk);
                i_shift_register_ack = 1'b0;
            end
        join
        chk("t5_data_coll",  int'(o_shift_register), 'h033);
        chk("t5_ov_coll",    int'(o_data_overrun), 0);
        chk("t5_valid_coll", int'(o_shift_register_valid), 1);

        // Disable in the middle of DATA: partial 0xFF frame must vanish.
        fork
            send_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b1);
            begin
                @(ev_start);
                wait_clks(BIT_CLKS * 4 + BIT_CLKS / 2);
                i_rx_enable = 1'b0;
                wait_clks(10);
                i_rx_enable = 1'b1;
            end
        join
        chk("t6_data_held",  int'(o_shift_register), 'h033);
        chk("t6_valid_held", int'(o_shift_register_valid), 1);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        chk("t6_data_5a",  int'(o_shift_register), 'h05A);
        chk("t6_valid_5a", int'(o_shift_register_valid), 1);

        // Reset in the middle of a 0xF8 frame.
        fork
            send_frame(9'h0F8, 8, 1'b0, 1'b0, 1'b1);
            begin
                @(ev_start);
                wait_clks(BIT_CLKS * 5 + BIT_CLKS / 2);
                i_rst = 1'b1;
                @(negedge i_clk);
                chk_all_zero("t6_rst");
                i_rst = 1'b0;
            end
        join
        chk("t6_no_word_after_rst", int'(o_shift_register_valid), 0);
        chk("t6_data_after_rst",    int'(o_shift_register), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
